// File: rtl/clk_div1.sv
// Fixed-ratio clock divider: 50 % duty square wave clk1 plus a one-cycle pulse on each clk1 rise.
// Optional macro CLK_DIV1_FAST_SIM_EN selects the short SIM_DIV ratio for simulation builds.
module clk_div1 #(
   parameter int CLK_IN_HZ  = 50_000_000,
   parameter int CLK_OUT_HZ = 1,
   parameter int SIM_DIV    = 10
) (
   input  logic clk50,
   input  logic rst,
   output logic clk1,
   output logic pulse
);

`ifdef CLK_DIV1_FAST_SIM_EN
   localparam int DIV = SIM_DIV;
`else
   localparam int DIV = CLK_IN_HZ / CLK_OUT_HZ;
`endif

   localparam int HALF  = DIV / 2;
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

   generate
      if ((DIV < 2) || ((DIV % 2) != 0) || ((CLK_IN_HZ % CLK_OUT_HZ) != 0)) begin : g_bad_cfg
         $error("clk_div1: DIV=%0d must be even and >= 2, and CLK_IN_HZ a multiple of CLK_OUT_HZ", DIV);
      end
   endgenerate

   logic [CNT_W-1:0] r_cnt;
   logic             r_clk1;
   logic             r_pulse;
   logic             w_term;

   assign w_term = (r_cnt == TERM);

   // The pulse is computed from the pre-toggle clk1 so it lands on the same edge as the 0->1 rise.
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_clk1  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         if (w_term) begin
            r_cnt  <= '0;
            r_clk1 <= ~r_clk1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         r_pulse <= w_term && !r_clk1;
      end
   end

   assign clk1  = r_clk1;
   assign pulse = r_pulse;

endmodule

// File: tb/tb_clk_div1.sv
// Bench for clk_div1: three ratios (10, 2, 100) chosen so results match with or without the fast-sim macro.
// Expected outputs come from the edge count since reset release, using period arithmetic.
module tb_clk_div1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic a_clk1, a_pulse;
   logic b_clk1, b_pulse;
   logic c_clk1, c_pulse;

   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;   // rising edges seen since rst was released

   logic [15:0] exp_q[$];
   logic [15:0] obs_q[$];

   always #5 clk = ~clk;

   clk_div1 #(.CLK_IN_HZ(10),  .CLK_OUT_HZ(1), .SIM_DIV(10))  u_a (.clk50(clk), .rst(rst), .clk1(a_clk1), .pulse(a_pulse));
   clk_div1 #(.CLK_IN_HZ(2),   .CLK_OUT_HZ(1), .SIM_DIV(2))   u_b (.clk50(clk), .rst(rst), .clk1(b_clk1), .pulse(b_pulse));
   clk_div1 #(.CLK_IN_HZ(100), .CLK_OUT_HZ(1), .SIM_DIV(100)) u_c (.clk50(clk), .rst(rst), .clk1(c_clk1), .pulse(c_pulse));

   // clk1 is high during every odd half-period; the pulse marks the start of each high half.
   function automatic logic m_clk1(int edges, int half);
      return ((edges / half) % 2) == 1;
   endfunction

   function automatic logic m_pulse(int edges, int half);
      return (edges >= half) && (((edges - half) % (2 * half)) == 0);
   endfunction

   task automatic chk(string tag, logic obs, logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   task automatic chk_int(string tag, int obs, int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
      end
   endtask

   task automatic check_model(string tag);
      chk({tag, "_a_clk1"},  a_clk1,  m_clk1(k, 5));
      chk({tag, "_a_pulse"}, a_pulse, m_pulse(k, 5));
      chk({tag, "_b_clk1"},  b_clk1,  m_clk1(k, 1));
      chk({tag, "_b_pulse"}, b_pulse, m_pulse(k, 1));
      chk({tag, "_c_clk1"},  c_clk1,  m_clk1(k, 50));
      chk({tag, "_c_pulse"}, c_pulse, m_pulse(k, 50));
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_a_clk1"},  a_clk1,  1'b0);
      chk({tag, "_a_pulse"}, a_pulse, 1'b0);
      chk({tag, "_b_clk1"},  b_clk1,  1'b0);
      chk({tag, "_b_pulse"}, b_pulse, 1'b0);
      chk({tag, "_c_clk1"},  c_clk1,  1'b0);
      chk({tag, "_c_pulse"}, c_pulse, 1'b0);
   endtask

   task automatic step(string tag);
      @(posedge clk);
      if (!rst) k++;
      @(negedge clk);
      check_model(tag);
   endtask

   // Fire rst dly ns after a rising edge, confirm the immediate clear, hold, then release at a falling edge.
   task automatic async_reset(int dly, int hold);
      @(posedge clk);
      k++;
      #1;
      check_model("pre_rst");
      #(dly - 1);
      rst = 1'b1;
      #1;
      check_zero("async_clear");
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_zero("rst_hold");
      end
      @(negedge clk);
      rst = 1'b0;
      k = 0;
   endtask

   initial begin
      int last_pk;
      int n_pulse;
      logic prev_clk1;

      // Reset values: rst high 10..20 ns.
      #10;
      rst = 1'b1;
      #1;
      check_zero("rst_imm");
      @(negedge clk);
      check_zero("rst_15");
      rst = 1'b0;
      k = 0;

      // First rise on the 5th edge (65 ns), fall at 115 ns, next rise at 165 ns.
      for (int i = 0; i < 16; i++) step("first");

      // Steady state: 200 cycles, 20 pulses of dut a spaced 10 apart and aligned to clk1 rises.
      exp_q.delete();
      obs_q.delete();
      for (int e = k + 1; e <= k + 200; e++)
         if (m_pulse(e, 5)) exp_q.push_back(16'(e));
      n_pulse = 0;
      last_pk = -1;
      for (int i = 0; i < 200; i++) begin
         prev_clk1 = a_clk1;
         step("steady");
         if (a_pulse) begin
            n_pulse++;
            obs_q.push_back(16'(k));
            chk("align_rise", prev_clk1 == 1'b0 && a_clk1 == 1'b1, 1'b1);
            if (last_pk >= 0) chk_int("spacing", k - last_pk, 10);
            last_pk = k;
         end
      end
      chk_int("pulse_count", n_pulse, 20);
      chk_int("pulse_q_size", obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0)
         chk_int("pulse_edge", int'(obs_q.pop_front()), int'(exp_q.pop_front()));

      // Directed mid-period reset 3 ns after a clk1 rise of dut a.
      for (int i = 0; i < 20 && (k % 10) != 4; i++) step("align");
      async_reset(3, 2);
      for (int i = 0; i < 12; i++) step("after_rst");

      // Randomized run lengths and reset positions.
      for (int r = 0; r < 8; r++) begin
         int run_len;
         run_len = $urandom_range(1, 120);
         for (int i = 0; i < run_len; i++) step("rand_run");
         async_reset($urandom_range(1, 4), $urandom_range(0, 3));
      end
      for (int i = 0; i < 110; i++) step("tail");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
